// File: rtl/ex_mem_pkg.sv
// Shared definitions for the execute/memory pipeline register.
// Stall-bit positions and the per-edge action decode used by ex_mem.
package ex_mem_pkg;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_FLUSH
    } ex_mem_act_e;

    // Flush dominates; ex running means advance even if mem claims a stall.
    function automatic ex_mem_act_e decode_act(input logic flush,
                                               input logic ex_stall,
                                               input logic mem_stall);
        if (flush)
            return ACT_FLUSH;
        if (!ex_stall)
            return ACT_ADVANCE;
        return mem_stall ? ACT_HOLD : ACT_BUBBLE;
    endfunction

endpackage

// File: rtl/ex_mem.sv
// Execute-to-memory pipeline register with multi-cycle multiply loop-back state.
// Optional bubble counter enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 6
`ifdef EX_MEM_PERF_CNT_EN
    ,
    parameter int PERF_W  = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [STALL_W-1:0]  stall,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] hilo_temp_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [2*DATA_W-1:0] hilo_temp_o,
    output logic [CNT_W-1:0]    cnt_o
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]   perf_bubble_cnt
`endif
);

    ex_mem_act_e act;
    logic        unused_stall;

    assign act          = decode_act(flush, stall[STALL_EX], stall[STALL_MEM]);
    assign unused_stall = ^stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd      <= '0;
            mem_wreg    <= 1'b0;
            mem_wdata   <= '0;
            mem_hi      <= '0;
            mem_lo      <= '0;
            mem_whilo   <= 1'b0;
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end else begin
            case (act)
                ACT_FLUSH: begin
                    mem_wd      <= '0;
                    mem_wreg    <= 1'b0;
                    mem_wdata   <= '0;
                    mem_hi      <= '0;
                    mem_lo      <= '0;
                    mem_whilo   <= 1'b0;
                    hilo_temp_o <= '0;
                    cnt_o       <= '0;
                end
                // Memory sees a no-op while execute keeps accumulating.
                ACT_BUBBLE: begin
                    mem_wd      <= '0;
                    mem_wreg    <= 1'b0;
                    mem_wdata   <= '0;
                    mem_hi      <= '0;
                    mem_lo      <= '0;
                    mem_whilo   <= 1'b0;
                    hilo_temp_o <= hilo_temp_i;
                    cnt_o       <= cnt_i;
                end
                ACT_HOLD: begin
                end
                default: begin
                    mem_wd      <= ex_wd;
                    mem_wreg    <= ex_wreg;
                    mem_wdata   <= ex_wdata;
                    mem_hi      <= ex_hi;
                    mem_lo      <= ex_lo;
                    mem_whilo   <= ex_whilo;
                    hilo_temp_o <= '0;
                    cnt_o       <= '0;
                end
            endcase
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    // Survives flush on purpose: it measures the whole run, not one instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_bubble_cnt <= '0;
        else if (act == ACT_BUBBLE)
            perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
    end
`endif

endmodule
